// File: rtl/tt_lut_engine_pkg.sv
// Shared types and constants for the programmable truth-table engine.
package tt_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2
   } tt_state_e;

   localparam int TT_MAX_IN  = 6;
   localparam int TT_MAX_OUT = 4;

   function automatic int tt_rows(input int n);
      return 1 << n;
   endfunction

endpackage

// File: rtl/tt_lut_engine_if.sv
// Config, input-vector and result streams of the truth-table engine.
interface tt_lut_engine_if #(
   parameter int NUM_IN  = 2,
   parameter int NUM_OUT = 1
);
   logic               cfg_start;
   logic               cfg_valid;
   logic               cfg_ready;
   logic [NUM_OUT-1:0] cfg_data;
   logic               cfg_done;
   logic               in_valid;
   logic               in_ready;
   logic [NUM_IN-1:0]  in_data;
   logic               out_valid;
   logic               out_ready;
   logic [NUM_OUT-1:0] out_data;

   modport master (
      output cfg_start, cfg_valid, cfg_data, in_valid, in_data, out_ready,
      input  cfg_ready, cfg_done, in_ready, out_valid, out_data
   );

   modport slave (
      input  cfg_start, cfg_valid, cfg_data, in_valid, in_data, out_ready,
      output cfg_ready, cfg_done, in_ready, out_valid, out_data
   );
endinterface

// File: rtl/tt_lut_engine_table_mem.sv
// ROWS x NUM_OUT flop table: one write port, synchronous clear, async read.
module tt_table_mem
   import tt_pkg::*;
#(
   parameter int NUM_IN  = 2,
   parameter int NUM_OUT = 1
) (
   input  logic               clk,
   input  logic               clr_i,
   input  logic               we_i,
   input  logic [NUM_IN-1:0]  waddr_i,
   input  logic [NUM_OUT-1:0] wdata_i,
   input  logic [NUM_IN-1:0]  raddr_i,
   output logic [NUM_OUT-1:0] rdata_o
);
   localparam int ROWS = tt_rows(NUM_IN);

   logic [ROWS-1:0][NUM_OUT-1:0] mem_q;

   always_ff @(posedge clk) begin
      if (clr_i)     mem_q <= '0;
      else if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/tt_lut_engine.sv
// Truth-table engine top: load FSM, row counter and one-entry result register.
module tt_lut_engine
   import tt_pkg::*;
#(
   parameter int NUM_IN  = 2,
   parameter int NUM_OUT = 1
) (
   input  logic           clk,
   input  logic           rst,
   tt_lut_engine_if.slave bus
);
   localparam int              ROWS     = tt_rows(NUM_IN);
   localparam logic [NUM_IN:0] LAST_ROW = (NUM_IN+1)'(ROWS-1);

   tt_state_e          state_q;
   logic [NUM_IN:0]    row_q;
   logic               cfg_ready_q;
   logic               cfg_done_q;
   logic               out_valid_q;
   logic [NUM_OUT-1:0] out_data_q;
   logic               in_ready;
   logic               beat;
   logic               accept;
   logic [NUM_OUT-1:0] rdata;

   // cfg_start outranks every handshake, so it masks both beat and accept.
   assign beat     = cfg_ready_q && bus.cfg_valid && !bus.cfg_start;
   assign in_ready = (state_q == RUN) && (!out_valid_q || bus.out_ready);
   assign accept   = bus.in_valid && in_ready && !bus.cfg_start;

   tt_table_mem #(
      .NUM_IN  (NUM_IN),
      .NUM_OUT (NUM_OUT)
   ) u_mem (
      .clk     (clk),
      .clr_i   (rst | bus.cfg_start),
      .we_i    (beat),
      .waddr_i (row_q[NUM_IN-1:0]),
      .wdata_i (bus.cfg_data),
      .raddr_i (bus.in_data),
      .rdata_o (rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= EMPTY;
         row_q       <= '0;
         cfg_ready_q <= 1'b0;
         cfg_done_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else if (bus.cfg_start) begin
         state_q     <= LOAD;
         row_q       <= '0;
         cfg_ready_q <= 1'b1;
         cfg_done_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         cfg_done_q <= 1'b0;
         case (state_q)
            LOAD: begin
               if (beat) begin
                  row_q <= row_q + 1'b1;
                  if (row_q == LAST_ROW) begin
                     state_q     <= RUN;
                     cfg_ready_q <= 1'b0;
                     cfg_done_q  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (accept) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= rdata;
               end else if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.cfg_ready = cfg_ready_q;
   assign bus.cfg_done  = cfg_done_q;
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_tt_lut_engine.sv
// Directed + random checks of tt_lut_engine against a transaction-level model.
module tb_tt_lut_engine;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tt_lut_engine_if #(.NUM_IN(2), .NUM_OUT(1)) busA ();
   tt_lut_engine_if #(.NUM_IN(6), .NUM_OUT(4)) busB ();

   tt_lut_engine #(.NUM_IN(2), .NUM_OUT(1)) dutA (.clk(clk), .rst(rst), .bus(busA));
   tt_lut_engine #(.NUM_IN(6), .NUM_OUT(4)) dutB (.clk(clk), .rst(rst), .bus(busB));

   int vecs = 0;
   int errs = 0;
   int qA[$];
   int qB[$];
   int tblA[4];
   bit ldA = 0, loadingA = 0, ldB = 0, loadingB = 0;
   int doneA = 0, doneB = 0, loadsA = 0, loadsB = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: check/record at the falling edge, return just after the rising edge.
   task automatic cyc();
      bit accA, accB;
      @(negedge clk);
      accA = busA.in_valid && ldA && (qA.size() == 0 || busA.out_ready);
      check("A_cfg_ready", 32'(busA.cfg_ready), 32'(loadingA));
      check("A_in_ready",  32'(busA.in_ready),  32'(accA || (!busA.in_valid && ldA && (qA.size() == 0 || busA.out_ready))));
      check("A_out_valid", 32'(busA.out_valid), 32'(qA.size() != 0));
      if (qA.size() != 0) check("A_out_data", 32'(busA.out_data), qA[0]);
      if (busA.cfg_done) doneA++;
      if (busA.cfg_start || rst) qA.delete();
      else begin
         if (busA.out_valid && busA.out_ready && qA.size() != 0) void'(qA.pop_front());
         if (accA) qA.push_back(tblA[busA.in_data]);
      end

      accB = busB.in_valid && ldB && (qB.size() == 0 || busB.out_ready);
      check("B_cfg_ready", 32'(busB.cfg_ready), 32'(loadingB));
      check("B_in_ready",  32'(busB.in_ready),  32'(ldB && (qB.size() == 0 || busB.out_ready)));
      check("B_out_valid", 32'(busB.out_valid), 32'(qB.size() != 0));
      if (qB.size() != 0) check("B_out_data", 32'(busB.out_data), qB[0]);
      if (busB.cfg_done) doneB++;
      if (busB.cfg_start || rst) qB.delete();
      else begin
         if (busB.out_valid && busB.out_ready && qB.size() != 0) void'(qB.pop_front());
         if (accB) qB.push_back(int'(busB.in_data) % 16);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic loadA(input logic [3:0] rows, input int nstart);
      busA.in_valid  = 1'b0;
      busA.cfg_start = 1'b1;
      cyc();
      loadingA = 1;
      ldA      = 0;
      check("A_start_out_valid", 32'(busA.out_valid), 0);
      check("A_start_cfg_ready", 32'(busA.cfg_ready), 1);
      check("A_start_in_ready",  32'(busA.in_ready),  0);
      busA.out_ready = 1'b1;
      repeat (nstart - 1) cyc();
      busA.cfg_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            busA.cfg_valid = 1'b0;
            busA.cfg_data  = 1'($urandom);
            cyc();
         end
         busA.cfg_valid = 1'b1;
         busA.cfg_data  = rows[i];
         cyc();
      end
      busA.cfg_valid = 1'b0;
      loadingA = 0;
      ldA      = 1;
      loadsA++;
      for (int i = 0; i < 4; i++) tblA[i] = int'(rows[i]);
      check("A_cfg_done", 32'(busA.cfg_done), 1);
      check("A_first_in_ready", 32'(busA.in_ready), 1);
   endtask

   task automatic streamA(input int n);
      for (int k = 0; k < n; k++) begin
         busA.in_valid  = ($urandom_range(0, 3) != 0);
         busA.in_data   = 2'($urandom);
         busA.out_ready = ($urandom_range(0, 2) != 0);
         cyc();
      end
      busA.in_valid  = 1'b0;
      busA.out_ready = 1'b1;
      cyc();
      cyc();
   endtask

   initial begin
      busA.cfg_start = 0; busA.cfg_valid = 0; busA.cfg_data = '0;
      busA.in_valid  = 0; busA.in_data   = '0; busA.out_ready = 1;
      busB.cfg_start = 0; busB.cfg_valid = 0; busB.cfg_data = '0;
      busB.in_valid  = 0; busB.in_data   = '0; busB.out_ready = 1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // reset state
      check("A_rst_cfg_ready", 32'(busA.cfg_ready), 0);
      check("A_rst_cfg_done",  32'(busA.cfg_done),  0);
      check("A_rst_in_ready",  32'(busA.in_ready),  0);
      check("A_rst_out_valid", 32'(busA.out_valid), 0);
      check("A_rst_out_data",  32'(busA.out_data),  0);
      check("B_rst_out_data",  32'(busB.out_data),  0);

      // no table: vectors are refused
      busA.in_valid = 1'b1;
      busA.in_data  = 2'd3;
      repeat (3) cyc();
      busA.in_valid = 1'b0;

      // rows 0,0,1,0 then vectors 0..3 back to back
      loadA(4'b0100, 1);
      for (int v = 0; v < 4; v++) begin
         busA.in_valid = 1'b1;
         busA.in_data  = 2'(v);
         cyc();
         check("A_t1_valid", 32'(busA.out_valid), 1);
         check("A_t1_data",  32'(busA.out_data),  32'(v == 2));
      end
      busA.in_valid = 1'b0;
      cyc();

      // backpressure for 3 cycles after the first result
      busA.in_valid = 1'b1;
      busA.in_data  = 2'd2;
      cyc();
      busA.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         busA.in_data = 2'($urandom);
         cyc();
         check("A_stall_data", 32'(busA.out_data), 1);
      end
      busA.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         busA.in_data = 2'($urandom);
         cyc();
      end
      busA.in_valid = 1'b0;
      cyc();
      streamA(60);

      // reload while a result is pending
      busA.in_valid  = 1'b1;
      busA.in_data   = 2'd1;
      cyc();
      busA.in_valid  = 1'b0;
      busA.out_ready = 1'b0;
      loadA(4'b0111, 1);
      busA.in_valid = 1'b1;
      busA.in_data  = 2'd3;
      cyc();
      check("A_t4_v3", 32'(busA.out_data), 0);
      busA.in_data  = 2'd0;
      cyc();
      check("A_t4_v0", 32'(busA.out_data), 1);
      busA.in_valid = 1'b0;
      cyc();

      // multi-cycle start restarts the load
      loadA(4'($urandom), 2);
      streamA(40);

      // reset after two row beats
      busA.cfg_start = 1'b1;
      cyc();
      busA.cfg_start = 1'b0;
      loadingA = 1;
      ldA      = 0;
      for (int i = 0; i < 2; i++) begin
         busA.cfg_valid = 1'b1;
         busA.cfg_data  = 1'b1;
         cyc();
      end
      busA.cfg_valid = 1'b0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      loadingA = 0;
      check("A_mid_rst_cfg_ready", 32'(busA.cfg_ready), 0);
      check("A_mid_rst_in_ready",  32'(busA.in_ready),  0);
      check("A_mid_rst_out_data",  32'(busA.out_data),  0);
      busA.in_valid = 1'b1;
      busA.in_data  = 2'd0;
      repeat (3) cyc();
      busA.in_valid = 1'b0;
      loadA(4'($urandom), 1);
      streamA(80);

      // 6-in/4-out table with row i = i[3:0]
      busB.cfg_start = 1'b1;
      cyc();
      busB.cfg_start = 1'b0;
      loadingB = 1;
      for (int i = 0; i < 64; i++) begin
         busB.cfg_valid = 1'b1;
         busB.cfg_data  = 4'(i);
         cyc();
         if (i == 62) check("B_no_early_done", 32'(busB.cfg_done), 0);
      end
      busB.cfg_valid = 1'b0;
      loadingB = 0;
      ldB      = 1;
      loadsB++;
      check("B_cfg_done", 32'(busB.cfg_done), 1);
      for (int v = 0; v < 64; v++) begin
         busB.in_valid = 1'b1;
         busB.in_data  = 6'(v);
         cyc();
         check("B_seq_data", 32'(busB.out_data), 32'(v % 16));
      end
      for (int k = 0; k < 80; k++) begin
         busB.in_valid  = ($urandom_range(0, 3) != 0);
         busB.in_data   = 6'($urandom);
         busB.out_ready = ($urandom_range(0, 2) != 0);
         cyc();
      end
      busB.in_valid  = 1'b0;
      busB.out_ready = 1'b1;
      cyc();
      cyc();

      check("A_done_pulses", 32'(doneA), 32'(loadsA));
      check("B_done_pulses", 32'(doneB), 32'(loadsB));
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/tt_lut_engine.md
# tt_lut_engine

Programmable truth-table evaluator: the parametrised successor to our fixed, hard-coded truth-table gate modules. A host loads an arbitrary `NUM_IN`-input, `NUM_OUT`-output truth table row by row, then streams input vectors through it. Each vector returns its looked-up output row over a valid/ready stream. The block sits between the netlist-synthesis test harness and downstream gate-assignment checkers, so candidate logic functions can be exercised without re-synthesising RTL.

## Interface
Parameters:
- `NUM_IN`, default 2: number of logic inputs, legal 1..6; the table has `ROWS = 2**NUM_IN` rows.
- `NUM_OUT`, default 1: number of output functions, legal 1..4; the row width.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `cfg_start`  in  1  single-cycle pulse; begin a (re)load of the table.
- `cfg_valid`  in  1  row-data beat valid.
- `cfg_ready`  out  1  block accepts a row beat.
- `cfg_data`  in  NUM_OUT  output values for the current row.
- `cfg_done`  out  1  one-cycle pulse after the last row is written.
- `in_valid`  in  1  input vector valid.
- `in_ready`  out  1  block accepts an input vector.
- `in_data`  in  NUM_IN  input vector; bit 0 is in1, bit NUM_IN-1 is the MSB of the row index.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  NUM_OUT  table row addressed by the accepted `in_data`.

## Operation
- States:
  - `EMPTY`: no table loaded. This is the state after reset.
  - `LOAD`: rows are being written.
  - `RUN`: the table is valid and vectors are being evaluated.
- Reset:
  - State goes to `EMPTY`.
  - Table is cleared to all 0 (every row defaults to 0).
  - Row counter is 0.
  - `cfg_ready`, `cfg_done`, `in_ready` and `out_valid` are 0; `out_data` is 0.
- `cfg_start` in any state:
  - State goes to `LOAD`.
  - Row counter goes to 0.
  - Table is cleared to 0.
  - Any pending result is discarded (`out_valid` goes to 0 next cycle).
  - `cfg_start` takes priority over every same-cycle handshake.
- `LOAD`:
  - `cfg_ready` = 1.
  - On `cfg_valid && cfg_ready`: write `cfg_data` to `table[row]` and increment `row`. Rows are written strictly in order 0..ROWS-1.
  - When row ROWS-1 is written, go to `RUN` and pulse `cfg_done` the next cycle.
  - `in_ready` = 0 throughout `LOAD`.
- `EMPTY` and `RUN`:
  - `cfg_ready` = 0; `cfg_valid` is ignored.
  - `in_ready` = 1 only in `RUN`, and only when `!out_valid || out_ready`.
- Evaluation in `RUN`: on an accepted vector, `out_data <= table[in_data]` and `out_valid <= 1`.
- Output handshake:
  - When `out_valid && out_ready` and no new vector is accepted in the same cycle, `out_valid` drops to 0.
  - While `out_valid && !out_ready`, `out_data` is held stable.
- Row counter is `NUM_IN+1` bits wide, so it never wraps during a load.

## Timing
- Load: ROWS accepted beats. The earliest first vector is accepted in the cycle after the last row beat (`in_ready` is high in that cycle).
- Evaluation latency: 1 cycle, from accepted vector to `out_valid`.
- Throughput: 1 vector per cycle while `out_ready` = 1.
- Simultaneous pop and push: the new result replaces the old one in the same edge, and `out_valid` stays 1.
- Reset asserted mid-load or mid-stream: on the next edge the block is fully in its reset state; partially loaded rows are lost.
- `cfg_start` held for more than one cycle: each asserted cycle restarts the load (row counter 0).

## Structure
- Package `tt_pkg`:
  - state enum `tt_state_e` {`EMPTY`, `LOAD`, `RUN`};
  - constants `TT_MAX_IN = 6` and `TT_MAX_OUT = 4`;
  - function `tt_rows(n)` returning `2**n`.
- Sub-module `tt_table_mem`:
  - ROWS×NUM_OUT flop array;
  - write port (`we`, `waddr`, `wdata`), synchronous clear, asynchronous read port;
  - clear is driven by `rst | cfg_start`.
- Top level holds the FSM, the row counter and the one-entry output register.

## Test plan
1. NUM_IN=2, NUM_OUT=1; load rows 0,0,1,0; stream vectors 0,1,2,3 with `out_ready`=1 -> `out_data` 0,0,1,0 on 4 consecutive cycles, each one cycle after its input; `cfg_done` pulses once.
2. After reset, hold `in_valid`=1 with no table loaded -> `in_ready`=0, `out_valid` stays 0.
3. Backpressure: table loaded, `out_ready`=0 for 3 cycles after the first result -> `in_ready`=0 and `out_data` stable; release `out_ready` -> stream resumes with no loss or duplication.
4. `cfg_start` while `out_valid`=1 -> next cycle `out_valid`=0, `cfg_ready`=1, `in_ready`=0; load rows 1,1,1,0 -> vector 3 returns 0 and vector 0 returns 1.
5. `rst` asserted after 2 of 4 row beats -> next cycle state is `EMPTY`, table all 0, `cfg_ready`=0; a fresh full load is required before evaluation.
6. NUM_IN=6, NUM_OUT=4; load row i = i[3:0] -> all 64 vectors return `in_data[3:0]`; `cfg_done` fires after exactly 64 beats.
